// File: rtl/minilab_0.sv
// minilab_0: small synchronous read-only lookup table with a one-hot select.
//
// Holds DEPTH words of DATA_W bits in rom_memory. On a rising clk with en=1
// and exactly one address bit set, the selected word is registered onto out.
// Any other select (none or several bits set), or en=0, registers zero.
// Entries are never ORed or merged.
//
// Ports:
//   clk      in   1       clock, rising-edge
//   rst      in   1       asynchronous active-high reset, clears out at once
//   en       in   1       read enable, sampled on rising clk
//   address  in   DEPTH   one-hot entry select, bit i selects entry i
//   out      out  DATA_W  registered read data, 1-cycle latency
//
// rom_memory is a plain variable with a declaration initialiser and no
// procedural driver, so a testbench may overwrite entries hierarchically.
// Entry i powers up as 8'h11*(i+1), truncated to DATA_W bits.
// Reset touches only the output register, never the table.

module minilab_0 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DEPTH-1:0]  address,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [DEPTH-1:0][DATA_W-1:0] rom_t;

  function automatic rom_t rom_init();
    rom_t r;
    for (int i = 0; i < int'(DEPTH); i++) begin
      r[i] = DATA_W'(32'h11 * (i + 1));
    end
    return r;
  endfunction

  localparam rom_t RomInit = rom_init();

  // Indexed as rom_memory[i] for entry i.
  rom_t rom_memory = RomInit;

  logic [CntW-1:0]   sel_cnt;
  logic [IdxW-1:0]   sel_idx;
  logic              sel_valid;
  logic [DATA_W-1:0] out_d;
  logic [DATA_W-1:0] out_q;

  // Priority-free decode: count the set bits and OR together the indices of
  // every set bit. The index is only meaningful when exactly one bit is set,
  // which sel_valid guarantees before it is used.
  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      sel_cnt = sel_cnt + CntW'(address[i]);
      if (address[i]) begin
        sel_idx = sel_idx | IdxW'(i);
      end
    end
    sel_valid = (sel_cnt == CntW'(1));
  end

  always_comb begin
    out_d = '0;
    if (en && sel_valid) begin
      out_d = rom_memory[sel_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_minilab_0.sv
// Self-checking bench for minilab_0: directed reset/default/disable/invalid
// cases, a hierarchical table load, a walking-bit sweep and random reads,
// all checked against a reference table kept in the bench.

module tb_minilab_0;

  localparam int DataW = 8;
  localparam int Depth = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [Depth-1:0] address;
  logic [DataW-1:0] out;

  int checks = 0;
  int errors = 0;

  logic [DataW-1:0] model_rom [Depth];

  minilab_0 #(
    .DATA_W(DataW),
    .DEPTH (Depth)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .address(address),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DataW-1:0] got,
                          input logic [DataW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: a read returns an entry only when exactly one bit is set.
  function automatic logic [DataW-1:0] model_read(input logic e,
                                                  input logic [Depth-1:0] a);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int i = 0; i < Depth; i++) begin
      if (a[i]) begin
        n++;
        pos = i;
      end
    end
    if (e && n == 1) return model_rom[pos];
    return '0;
  endfunction

  task automatic do_read(input string tag, input logic e, input logic [Depth-1:0] a);
    @(negedge clk);
    en      = e;
    address = a;
    @(posedge clk);
    #1;
    check_eq(tag, out, model_read(e, a));
  endtask

  initial begin
    logic [Depth-1:0] a;
    logic [DataW-1:0] v;

    for (int i = 0; i < Depth; i++) model_rom[i] = DataW'(8'h11 * (i + 1));

    rst     = 1'b1;
    en      = 1'b0;
    address = '0;
    #2;
    check_eq("reset_async", out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_held", out, 8'h00);

    @(negedge clk);
    rst = 1'b0;

    // Default contents.
    do_read("default_top", 1'b1, 8'b1000_0000);
    check_eq("default_top_const", out, 8'h88);
    for (int i = 0; i < Depth; i++) do_read("default_walk", 1'b1, Depth'(1) << i);

    // Disable and invalid selects.
    do_read("pre_disable", 1'b1, 8'b0000_0100);
    do_read("disable", 1'b0, 8'b0000_0001);
    check_eq("disable_const", out, 8'h00);
    do_read("pre_invalid", 1'b1, 8'b0000_0100);
    do_read("invalid_zero", 1'b1, 8'h00);
    do_read("pre_invalid2", 1'b1, 8'b0000_0001);
    do_read("invalid_two", 1'b1, 8'b0000_0011);
    do_read("invalid_all", 1'b1, 8'hff);

    // Hierarchical load of new contents.
    @(negedge clk);
    for (int i = 0; i < Depth; i++) begin
      v = DataW'($urandom_range(1, 255));
      model_rom[i]      = v;
      dut.rom_memory[i] = v;
    end
    for (int i = 0; i < Depth; i++) do_read("walk", 1'b1, Depth'(1) << i);

    // Reset mid-cycle during reads.
    do_read("pre_reset", 1'b1, 8'b0010_0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("reset_mid_cycle", out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hold_en", out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_read("after_reset", 1'b1, 8'b0010_0000);
    for (int i = 0; i < Depth; i++) check_eq("rom_kept", dut.rom_memory[i], model_rom[i]);

    // Random reads mixing one-hot and arbitrary selects.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 0) a = Depth'(1) << $urandom_range(0, Depth - 1);
      else                           a = Depth'($urandom);
      do_read("random", ($urandom_range(0, 3) != 0), a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
